// File: rtl/calc_pkg.sv
// Shared encodings for the calc_core datapath: opcodes, R-type functs,
// ALU operations and the decoded control bundle.
package calc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_op_e;

    typedef struct packed {
        logic    reg_we;
        logic    mem_we;
        logic    mem_to_reg;
        logic    alu_src_imm;
        logic    dst_rd;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/calc_if.sv
// Debug observation bundle of calc_core: current fetch and writeback activity.
interface calc_if;

    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [31:0] wb_data_out;
    logic        wb_en_out;

    modport master (output pc_out, instr_out, wb_data_out, wb_en_out);
    modport slave  (input  pc_out, instr_out, wb_data_out, wb_en_out);

endinterface

// File: rtl/calc_alu.sv
// Combinational integer ALU; all arithmetic wraps modulo 2^32.
module calc_alu
    import calc_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);

    always_comb begin
        y = 32'h0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLL: y = b << shamt;
            default: y = 32'h0;
        endcase
    end

endmodule

// File: rtl/calc_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// Reads see the pre-edge value; $0 is never stored and always reads zero.
module calc_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0][31:0] regs_q;
    logic [31:0][31:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && wa != 5'd0) regs_d[wa] = wd;
    end

    always_ff @(posedge clk) begin
        if (reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs_q[ra2];

endmodule

// File: rtl/calc_state.sv
// PC register and the word memory used for both instruction and data storage.
module calc_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= RESET_PC;
        else       q <= d;
    end

endmodule

// Byte address in, word index out: low two bits dropped and the top bits
// truncated so out-of-range addresses wrap modulo depth. Never cleared.
module calc_ram #(
    parameter int WORDS = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [WORDS];
    logic [AW-1:0] idx;
    logic          unused_addr;

    assign idx         = addr[AW+1:2];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign rdata       = mem[idx];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

endmodule

// File: rtl/calc_core.sv
// Single-cycle MIPS-subset calculator: fetch, decode, execute, memory and
// writeback all resolve combinationally and commit on the next clk edge.
module calc_core
    import calc_pkg::*;
#(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 8192,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic   clk,
    input  logic   reset,
    calc_if.master dbg
);

    logic [31:0] pc_q, pc_d, instr;
    logic [31:0] rs_val, rt_val, imm_sx, alu_b, alu_y, mem_rdata, wb_data;
    logic [31:0] pc_plus4, br_target, j_target;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wr_addr;
    logic        reg_we, mem_we, br_taken;
    ctrl_t       ctrl;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];

    calc_pc_reg #(.RESET_PC(RESET_PC)) PC (
        .clk   (clk),
        .reset (reset),
        .d     (pc_d),
        .q     (pc_q)
    );

    // Program is preloaded through the hierarchy; the write port stays idle.
    calc_ram #(.WORDS(IMEM_WORDS)) instMem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc_q),
        .wdata (32'h0),
        .rdata (instr)
    );

    // The all-zero word decodes as a true NOP rather than a $0 write attempt.
    always_comb begin
        ctrl = '0;
        if (instr != 32'h0) begin
            case (op)
                OP_RTYPE: begin
                    ctrl.reg_we = 1'b1;
                    ctrl.dst_rd = 1'b1;
                    case (funct)
                        FN_ADD:  ctrl.alu_op = ALU_ADD;
                        FN_SUB:  ctrl.alu_op = ALU_SUB;
                        FN_AND:  ctrl.alu_op = ALU_AND;
                        FN_OR:   ctrl.alu_op = ALU_OR;
                        FN_SLT:  ctrl.alu_op = ALU_SLT;
                        FN_SLL:  ctrl.alu_op = ALU_SLL;
                        default: ctrl.reg_we = 1'b0;
                    endcase
                end
                OP_ADDI: begin
                    ctrl.reg_we      = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                end
                OP_LW: begin
                    ctrl.reg_we      = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.mem_to_reg  = 1'b1;
                end
                OP_SW: begin
                    ctrl.mem_we      = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                end
                OP_BEQ: ctrl.branch = 1'b1;
                OP_BNE: begin
                    ctrl.branch    = 1'b1;
                    ctrl.branch_ne = 1'b1;
                end
                OP_J:    ctrl.jump = 1'b1;
                default: ctrl = '0;
            endcase
        end
    end

    calc_regfile rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (reg_we),
        .wa    (wr_addr),
        .wd    (wb_data)
    );

    calc_alu alu (
        .op    (ctrl.alu_op),
        .a     (rs_val),
        .b     (alu_b),
        .shamt (shamt),
        .y     (alu_y)
    );

    calc_ram #(.WORDS(DMEM_WORDS)) memory0 (
        .clk   (clk),
        .we    (mem_we),
        .addr  (alu_y),
        .wdata (rt_val),
        .rdata (mem_rdata)
    );

    always_comb begin
        imm_sx    = sext16(instr[15:0]);
        alu_b     = ctrl.alu_src_imm ? imm_sx : rt_val;
        wr_addr   = ctrl.dst_rd ? rd : rt;
        reg_we    = ctrl.reg_we & ~reset;
        mem_we    = ctrl.mem_we & ~reset;
        wb_data   = ctrl.mem_to_reg ? mem_rdata : alu_y;
        pc_plus4  = pc_q + 32'd4;
        br_target = pc_plus4 + {imm_sx[29:0], 2'b00};
        j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
        br_taken  = ctrl.branch & ((rs_val == rt_val) ^ ctrl.branch_ne);
        pc_d      = ctrl.jump ? j_target : (br_taken ? br_target : pc_plus4);
    end

    assign dbg.pc_out      = pc_q;
    assign dbg.instr_out   = instr;
    assign dbg.wb_en_out   = reg_we;
    assign dbg.wb_data_out = reg_we ? wb_data : 32'h0;

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: an ISA-level model fills an expectation
// queue per program; a negedge monitor drains and compares the debug ports.
module tb_calc_core;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wb_data;
        logic        wb_en;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    calc_if dbg_if();

    calc_core #(.IMEM_WORDS(1024), .DMEM_WORDS(8192), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (dbg_if)
    );

    always #5 clk = ~clk;

    exp_t        expq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog[1024];
    logic [31:0] m_regs[32];
    logic [31:0] m_mem[int];
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    // Architectural reference: executes one instruction on the model state.
    function automatic exp_t model_step();
        exp_t        e;
        logic [31:0] ins, a, b, sx, p4, nxt, val, ea;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        bit          we;
        int          key;
        ins = prog[(m_pc >> 2) % 32'd1024];
        a   = m_regs[ins[25:21]];
        b   = m_regs[ins[20:16]];
        sx  = 32'($signed(ins[15:0]));
        p4  = m_pc + 32'd4;
        nxt = p4;
        we  = 0;
        dst = 5'd0;
        val = 32'h0;
        op  = ins[31:26];
        fn  = ins[5:0];
        if (ins != 32'h0) begin
            if (op == 6'h00) begin
                we  = 1;
                dst = ins[15:11];
                case (fn)
                    6'h20:   val = a + b;
                    6'h22:   val = a - b;
                    6'h24:   val = a & b;
                    6'h25:   val = a | b;
                    6'h2A:   val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00:   val = b << ins[10:6];
                    default: we = 0;
                endcase
            end else if (op == 6'h08) begin
                we = 1; dst = ins[20:16]; val = a + sx;
            end else if (op == 6'h23) begin
                ea  = a + sx;
                key = int'((ea >> 2) % 32'd8192);
                we  = 1; dst = ins[20:16];
                val = m_mem.exists(key) ? m_mem[key] : 32'hDEAD_BEEF;
            end else if (op == 6'h2B) begin
                ea  = a + sx;
                key = int'((ea >> 2) % 32'd8192);
                m_mem[key] = b;
            end else if (op == 6'h04) begin
                if (a == b) nxt = p4 + (sx << 2);
            end else if (op == 6'h05) begin
                if (a != b) nxt = p4 + (sx << 2);
            end else if (op == 6'h02) begin
                nxt = {p4[31:28], ins[25:0], 2'b00};
            end
        end
        e.pc      = m_pc;
        e.instr   = ins;
        e.wb_en   = we;
        e.wb_data = we ? val : 32'h0;
        if (we && dst != 5'd0) m_regs[dst] = val;
        m_pc = nxt;
        return e;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && expq.size() > 0) begin
                mon_e = expq.pop_front();
                check("pc", dbg_if.pc_out, mon_e.pc);
                check("instr", dbg_if.instr_out, mon_e.instr);
                check("wb_en", {31'b0, dbg_if.wb_en_out}, {31'b0, mon_e.wb_en});
                check("wb_data", dbg_if.wb_data_out, mon_e.wb_data);
            end
        end
    end

    task automatic load_directed();
        for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
        prog[0]  = enc_i(8, 0, 1, 5);
        prog[1]  = enc_i(8, 0, 2, 7);
        prog[2]  = enc_r(1, 2, 3, 0, 'h20);
        prog[3]  = enc_r(1, 2, 6, 0, 'h22);
        prog[4]  = enc_r(1, 2, 7, 0, 'h2A);
        prog[5]  = enc_i(8, 0, 4, -1);
        prog[6]  = enc_r(4, 4, 4, 0, 'h20);
        prog[7]  = enc_r(1, 2, 0, 0, 'h20);
        prog[8]  = enc_i(4, 1, 1, 2);
        prog[9]  = enc_i(8, 0, 8, 99);
        prog[10] = enc_i(8, 0, 8, 98);
        prog[11] = enc_i('h2B, 0, 3, 16);
        prog[12] = enc_i('h23, 0, 5, 16);
        prog[13] = enc_i(5, 1, 1, 2);
        prog[14] = enc_r(0, 1, 9, 3, 'h00);
        prog[15] = enc_j('h14);
        prog[16] = enc_i(4, 1, 2, 5);
        prog[17] = enc_i(5, 1, 2, 2);
        prog[20] = enc_i('h3F, 1, 3, 0);
        prog[21] = enc_r(1, 2, 11, 0, 'h3F);
        prog[23] = enc_j('h10);
    endtask

    task automatic gen_random();
        logic [5:0] fns[6];
        int kind, rs, rt, rd, mimm, off;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
        for (int k = 0; k < 8; k++) prog[k] = enc_i('h2B, 0, 0, k * 4);
        for (int i = 8; i < 64; i++) begin
            kind = int'($urandom_range(0, 11));
            rs   = int'($urandom_range(0, 7));
            rt   = int'($urandom_range(0, 7));
            rd   = int'($urandom_range(0, 7));
            // word 0..7, junk low bits, optionally offset by -32768 to wrap
            mimm = int'($urandom_range(0, 7)) * 4 + int'($urandom_range(0, 3))
                 + (($urandom_range(0, 1) == 1) ? 'h8000 : 0);
            off  = int'($urandom_range(0, 10)) - 4;
            case (kind)
                0, 1, 2, 3, 4, 5: prog[i] = enc_r(rs, rt, rd, int'($urandom_range(0, 31)), int'(fns[kind]));
                6:  prog[i] = enc_i(8, rs, rt, int'($urandom_range(0, 65535)));
                7:  prog[i] = enc_i('h23, 0, rt, mimm);
                8:  prog[i] = enc_i('h2B, 0, rt, mimm);
                9:  prog[i] = enc_i(($urandom_range(0, 1) == 1) ? 4 : 5, rs, rt, off);
                10: prog[i] = enc_j(int'($urandom_range(0, 63)));
                default: prog[i] = ($urandom_range(0, 1) == 1) ? {6'h3F, 26'($urandom)}
                                                               : enc_r(rs, rt, rd, 0, 'h3F);
            endcase
        end
    endtask

    task automatic run(input int ncyc, input bit mid_reset);
        exp_t e;
        int   k;
        for (int i = 0; i < 1024; i++) dut.instMem.mem[i] = prog[i];
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", dbg_if.pc_out, 32'h0);
        check("rst_wb_en", {31'b0, dbg_if.wb_en_out}, 32'h0);
        check("rst_wb_data", dbg_if.wb_data_out, 32'h0);
        for (int i = 0; i < ncyc; i++) begin
            e = model_step();
            expq.push_back(e);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        k = 0;
        while (expq.size() != 0 && k < ncyc + 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d entries left, expected 0", expq.size());
            expq.delete();
        end
        reset = 1'b1;
        check("end_pc", dbg_if.pc_out, m_pc);
        for (int i = 0; i < 32; i++) check($sformatf("reg%0d", i), dut.rf.regs_q[i], m_regs[i]);
        foreach (m_mem[key]) check($sformatf("dmem%0d", key), dut.memory0.mem[key], m_mem[key]);
        if (mid_reset) begin
            @(posedge clk);
            #1;
            check("midrst_pc", dbg_if.pc_out, 32'h0);
            for (int i = 0; i < 32; i++) check($sformatf("midrst_reg%0d", i), dut.rf.regs_q[i], 32'h0);
            check("midrst_dmem4", dut.memory0.mem[4], 32'd12);
        end
    endtask

    initial begin
        reset = 1'b1;
        load_directed();
        run(24, 1'b0);
        check("plan_r3", dut.rf.regs_q[3], 32'd12);
        check("plan_r4", dut.rf.regs_q[4], 32'hFFFF_FFFE);
        check("plan_r5", dut.rf.regs_q[5], 32'd12);
        check("plan_r6", dut.rf.regs_q[6], 32'hFFFF_FFFE);
        check("plan_r7", dut.rf.regs_q[7], 32'd1);
        check("plan_r8", dut.rf.regs_q[8], 32'd0);
        check("plan_r9", dut.rf.regs_q[9], 32'd40);
        check("plan_dmem4", dut.memory0.mem[4], 32'd12);
        // same program, reset asserted while PC=0x14 is presented
        run(5, 1'b1);
        for (int r = 0; r < 3; r++) begin
            gen_random();
            run(120, 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
